// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction fetch (IF)
// stage and the memory access (MEM) stage. Each requester uses a level
// request / one-cycle acknowledge handshake. One memory transaction is in
// flight at a time and passes through three states:
//    IDLE : arbitrate and latch the winner's address/we/wdata
//    BUSY : hold port_req and the port fields until port_ack
//    RESP : pulse the owner's ack with the captured read data
// MEM requests normally beat IF requests. A saturating counter forces IF to
// win after STARVE_LIMIT consecutive MEM grants taken against a pending fetch.
// A pipeline flush suppresses the acknowledge of an in-flight fetch. The
// memory access itself still runs to completion.
//
// Parameters
//    ADDR_W       address width (requesters and memory port)
//    DATA_W       data width of the data path and the memory port (>= 32)
//    STARVE_LIMIT MEM wins against a pending fetch before IF is forced (1..15)
//
// Ports
//    clk_i, rst_i        clock, synchronous active-high reset
//    flush_i             branch-taken flush; kills the pending fetch response
//    if_req_i/addr_i     fetch request (level) and byte address
//    if_ack_o/rdata_o    fetch acknowledge pulse, instruction = port_rdata[31:0]
//    mem_req_i/we_i      data request (level), 1 = store
//    mem_addr_i/wdata_i  data byte address, store data
//    mem_ack_o/rdata_o   data acknowledge pulse, load data
//    stall_if_o          if_req & ~if_ack
//    stall_mem_o         mem_req & ~mem_ack
//    port_req_o/we_o     memory request (held until port_ack), write enable
//    port_addr_o/wdata_o memory address, write data
//    port_ack_i/rdata_i  memory completion pulse, read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [31:0]       if_rdata_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic              mem_ack_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              stall_if_o,
   output logic              stall_mem_o,
   output logic              port_req_o,
   output logic              port_we_o,
   output logic [ADDR_W-1:0] port_addr_o,
   output logic [DATA_W-1:0] port_wdata_o,
   input  logic              port_ack_i,
   input  logic [DATA_W-1:0] port_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic       OWN_IF  = 1'b0;
   localparam logic       OWN_MEM = 1'b1;
   localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t              state_q,    state_d;
   logic                owner_q,    owner_d;
   logic                we_q,       we_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [DATA_W-1:0]   wdata_q,    wdata_d;
   logic [3:0]          starve_q,   starve_d;
   logic                kill_if_q,  kill_if_d;
   logic [DATA_W-1:0]   cap_q,      cap_d;      // read data captured on port_ack
   logic [31:0]         if_hold_q,  if_hold_d;  // last delivered instruction
   logic [DATA_W-1:0]   mem_hold_q, mem_hold_d; // last delivered load data

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic if_elig;
   logic mem_elig;
   logic starved;
   logic grant_if;
   logic grant_mem;

   // A fetch raised in the same cycle as a flush is for a dead path, so it
   // does not compete for the port.
   assign if_elig   = if_req_i & ~flush_i;
   assign mem_elig  = mem_req_i;
   assign starved   = (starve_q >= LIMIT);
   assign grant_if  = if_elig & (~mem_elig | starved);
   assign grant_mem = mem_elig & ~grant_if;

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // flush_i is also tested directly so a flush landing in the RESP cycle
   // itself still drops the fetch response.
   assign if_ack_o    = (state_q == ST_RESP) && (owner_q == OWN_IF)
                        && !kill_if_q && !flush_i;
   assign mem_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_MEM);

   // During an ack the fresh capture is shown; otherwise the last delivered
   // value. A store ack never exposes the capture register.
   assign if_rdata_o  = if_ack_o ? cap_q[31:0] : if_hold_q;
   assign mem_rdata_o = (mem_ack_o && !we_q) ? cap_q : mem_hold_q;

   assign stall_if_o  = if_req_i  & ~if_ack_o;
   assign stall_mem_o = mem_req_i & ~mem_ack_o;

   assign port_req_o   = (state_q == ST_BUSY);
   assign port_we_o    = we_q;
   assign port_addr_o  = addr_q;
   assign port_wdata_o = wdata_q;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      kill_if_d  = kill_if_q;
      cap_d      = cap_q;
      if_hold_d  = if_hold_q;
      mem_hold_d = mem_hold_q;

      case (state_q)
         ST_IDLE: begin
            kill_if_d = 1'b0;

            if (grant_if || grant_mem) begin
               state_d = ST_BUSY;
               owner_d = grant_mem ? OWN_MEM : OWN_IF;
               if (grant_mem) begin
                  addr_d  = mem_addr_i;
                  we_d    = mem_we_i;
                  wdata_d = mem_wdata_i;
               end else begin
                  addr_d  = if_addr_i;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end

            // Counts only MEM wins taken while a fetch was waiting; any
            // cycle without a live fetch breaks the run.
            if (!if_elig || grant_if) begin
               starve_d = 4'd0;
            end else if (grant_mem && (starve_q < LIMIT)) begin
               starve_d = starve_q + 4'd1;
            end
         end

         ST_BUSY: begin
            if (flush_i && (owner_q == OWN_IF)) begin
               kill_if_d = 1'b1;
            end
            if (port_ack_i) begin
               state_d = ST_RESP;
               if (!((owner_q == OWN_MEM) && we_q)) begin
                  cap_d = port_rdata_i;
               end
            end
         end

         ST_RESP: begin
            state_d   = ST_IDLE;
            kill_if_d = 1'b0;
            if (if_ack_o) begin
               if_hold_d = cap_q[31:0];
            end
            if (mem_ack_o && !we_q) begin
               mem_hold_d = cap_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         starve_q   <= 4'd0;
         kill_if_q  <= 1'b0;
         cap_q      <= '0;
         if_hold_q  <= '0;
         mem_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         starve_q   <= starve_d;
         kill_if_q  <= kill_if_d;
         cap_q      <= cap_d;
         if_hold_q  <= if_hold_d;
         mem_hold_q <= mem_hold_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the instruction fetch stage and the memory access stage of the 5-stage pipelined processor. Each requester uses a request/acknowledge handshake. The block drives a request/acknowledge port toward a variable-latency memory and raises per-stage stall signals, which feed the existing PC_write/ifid_write stall path. Data accesses have priority over fetches, and a starvation guard bounds how long a fetch can be held off.

## Interface
- ADDR_W, 64: address width, both requesters and the memory port.
- DATA_W, 64: data width of the data path and the memory port.
- STARVE_LIMIT, 4: number of consecutive MEM grants won against a pending fetch before IF is forced to win. Legal range 1–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush (branch taken); kills fetch responses.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  32  fetched instruction, port_rdata[31:0].
- mem_req  in  1  data request; level, held until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  DATA_W  store data.
- mem_ack  out  1  one-cycle pulse; load data valid / store complete.
- mem_rdata  out  DATA_W  load data.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  mem_req & ~mem_ack (combinational).
- port_req  out  1  memory request; held until port_ack.
- port_we  out  1  memory write enable.
- port_addr  out  ADDR_W  memory address.
- port_wdata  out  DATA_W  memory write data.
- port_ack  in  1  memory completion; one cycle.
- port_rdata  in  DATA_W  memory read data; valid with port_ack.

## Operation
- **States.** IDLE, BUSY, RESP. A 1-bit owner register records the winner: IF = 0, MEM = 1.
- **IDLE: arbitration.**
  - Eligible: mem_req, and if_req & ~flush.
  - If both are eligible, MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - On a grant: latch owner, addr, we and wdata into the port registers; go to BUSY. A fetch grant forces port_we = 0 and port_wdata = 0.
- **BUSY.**
  - port_req = 1; port_we, port_addr and port_wdata are held stable.
  - On port_ack: capture port_rdata (unless owner = MEM with we = 1); go to RESP.
- **RESP.**
  - port_req = 0.
  - Pulse the owner's ack for one cycle and drive its rdata from the capture register.
  - Always go to IDLE next.
- **Starvation counter** (width 4, saturating at STARVE_LIMIT). Updated at the IDLE grant:
  - MEM granted while IF was eligible: increment.
  - IF granted: clear to 0.
  - IF not eligible: clear to 0.
- **Flush.**
  - Flush sampled high during BUSY or RESP of an IF transaction sets kill_if.
  - The memory transaction still completes, because memory cannot be aborted.
  - if_ack is suppressed in RESP when kill_if or flush is high. kill_if clears on entry to IDLE.
  - Flush never affects MEM transactions.
- **Rdata hold.** if_rdata and mem_rdata hold their last captured value between acks. A store ack leaves mem_rdata unchanged.
- **Ack input rule.** port_ack is ignored outside BUSY.

## Timing
- **Reset values.** All outputs 0; state IDLE; owner 0; starve_cnt 0; kill_if 0; if_rdata 0; mem_rdata 0.
- **Reset mid-transaction.** Reset during BUSY drops port_req on the next edge. The memory model must tolerate an abandoned request.
- **Minimum latency.**
  - Request seen in IDLE at cycle 0.
  - port_req = 1 from cycle 1.
  - port_ack at cycle 1 at the earliest.
  - Requester ack at cycle 2; IDLE at cycle 3.
  - Throughput: at most one transaction per 3 cycles. Latency is 2 + (memory wait cycles).
- **Request still high after ack.** A requester whose req is still high in the IDLE cycle after its ack is treated as a new request. Requesters must deassert or update req in the cycle of the ack.
- **Simultaneous requests.** A new request arriving while BUSY waits. Its stall is already asserted, since stall is combinational.
- **Stalls.** stall_if and stall_mem are low in the ack cycle, so the pipeline advances exactly on the ack.
- **Counter boundary.** STARVE_LIMIT = 1: IF and MEM alternate under continuous contention.

## Test plan
- **Single load.** mem_req = 1, mem_addr = 0x10, memory responds 0xDEAD_BEEF_0000_0001 with 0 waits. Required: port_req high in cycle 1 only, mem_ack in cycle 2, mem_rdata = 0xDEADBEEF00000001, stall_mem high in cycles 0–1.
- **Store with waits.** Store of 0x55 to addr 0x8, memory waits 3 cycles. Required: port_we = 1 and addr/wdata stable for all 4 BUSY cycles, mem_ack in cycle 5, mem_rdata unchanged.
- **Contention and starvation.** if_req and mem_req held high continuously with STARVE_LIMIT = 4. Required grant order: M M M M I M M M M I. After each IF grant, starve_cnt returns to 0.
- **Flush during fetch.** IF fetch in BUSY, flush pulsed during the wait. Required: the port transaction completes, no if_ack, returns to IDLE, and the next if_req is granted normally.
- **Reset mid-transaction.** rst asserted in the second BUSY cycle. Required: the next cycle has port_req = 0 and state IDLE, all acks 0, and the rdata registers 0.
- **Back-to-back fetch.** Fetches at addr 0x0 then 0x4, 0 waits. Required: if_ack in cycles 2 and 5, if_rdata equal to each word's low 32 bits.
